lc3_mem_arbiter: RTL
====================

LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

Interface
REQ-001 SHALL have parameter: WAIT_STATES, default 2, extra memory-access cycles after the first (legal 0..3).
REQ-002 SHALL have port: clk  in  1  single system clock; all state updates on posedge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: fetch_req  in  1 (instruction-fetch read request); fetch_addr  in  16 (fetch address).
REQ-005 SHALL have ports: fetch_ack  out  1 (one-cycle completion pulse); fetch_data  out  16 (registered fetched word).
REQ-006 SHALL have ports: data_req  in  1 (load/store request); data_we  in  1 (1 = store); data_addr  in  16 (address); data_wdata  in  16 (store data).
REQ-007 SHALL have ports: data_ack  out  1 (one-cycle completion pulse); data_rdata  out  16 (registered load word).
REQ-008 SHALL have ports: mem_en  out  1 (memory access strobe); mem_we  out  1 (memory write enable); mem_addr  out  16 (address); mem_wdata  out  16 (write data); mem_rdata  in  16 (read data).
REQ-009 SHALL have port: busy  out  1; high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE.
REQ-011 IDLE, no request: SHALL stay in IDLE; mem_en=0, mem_we=0, both acks 0.
REQ-012 IDLE, exactly one request high: SHALL grant it; latch addr, we (fetch always we=0) and wdata into internal registers; go to ACCESS.
REQ-013 IDLE, both requests high: SHALL grant the port not granted last; last_grant register resets to DATA, so the first conflict after reset goes to FETCH.
REQ-014 last_grant SHALL update only on a grant, never in other states.
REQ-015 ACCESS and WAIT: SHALL drive mem_en=1, mem_addr/mem_wdata from latched registers, mem_we = latched we.
REQ-016 ACCESS: SHALL go to WAIT with a 2-bit wait counter loaded with WAIT_STATES; if WAIT_STATES=0, SHALL go directly to DONE.
REQ-017 WAIT: counter decrements each cycle; at counter==1 SHALL go to DONE.
REQ-018 On the edge leaving the final ACCESS/WAIT cycle of a read, mem_rdata SHALL be captured into the granted port's data register (fetch_data or data_rdata).
REQ-019 Stores SHALL leave data_rdata unchanged; fetch_data SHALL change only on completed fetches.
REQ-020 DONE: SHALL pulse the granted port's ack high for exactly one cycle with its data register valid; mem_en=0; next state IDLE.
REQ-021 Latency: request first seen in IDLE at cycle t -> ack high at cycle t+2+WAIT_STATES; mem_en high for 1+WAIT_STATES cycles.
REQ-022 Requester SHALL hold req and operands until ack; arbiter ignores operand changes after grant.
REQ-023 Request dropped mid-transaction: transaction SHALL complete and ack SHALL still pulse.
REQ-024 Request high in cycle after ack: SHALL be treated as a new request (back-to-back supported, one IDLE cycle between transactions).
REQ-025 Ungranted request SHALL wait with no ack until granted; no request is ever lost.

Reset
REQ-026 On reset low: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, acks 0, fetch_data=0, data_rdata=0, wait counter 0, last_grant=DATA, busy=0, effective immediately without clock.
REQ-027 Reset during ACCESS/WAIT SHALL abort the access (mem_en/mem_we drop asynchronously) with no ack issued after release.
REQ-028 After reset release, first grant SHALL be possible on the first posedge with a request present.

Verification
REQ-029 WAIT_STATES=2, fetch_req, fetch_addr=16'h3000, mem_rdata=16'h1234 -> mem_en high 3 cycles, mem_we=0, fetch_ack at t+4, fetch_data=16'h1234.
REQ-030 WAIT_STATES=0, data_req, data_we=1, data_addr=16'h4000, data_wdata=16'hBEEF -> mem_en=mem_we=1 one cycle, mem_addr=16'h4000, data_ack at t+2, data_rdata unchanged.
REQ-031 Both requests high after reset, held -> fetch granted first, data granted next IDLE cycle; alternation on repeated conflicts.
REQ-032 Reset asserted during WAIT of a store -> mem_en/mem_we 0 immediately, no ack, busy=0, all outputs at reset values.
REQ-033 fetch_req dropped in ACCESS -> fetch_ack still pulses once at t+2+WAIT_STATES; no second transaction.
REQ-034 Back-to-back data loads (req re-raised after ack) -> one IDLE cycle between, two acks, each data_rdata matching its mem_rdata.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
//   Shares one single-port memory between the instruction-fetch path and the
//   load/store path of an LC-3 core. Only one access is in flight at a time.
//   Simultaneous requests alternate between the two ports so neither starves.
//   Each access holds mem_en for 1+WAIT_STATES cycles. After that the granted
//   port's ack pulses for one cycle.
//
// Parameters
//   WAIT_STATES  extra memory cycles after the first access cycle (0..3)
//
// Ports
//   clk, reset                  system clock; asynchronous active-low reset
//   fetch_req/addr              instruction-fetch read request
//   fetch_ack/data              completion pulse and registered fetched word
//   data_req/we/addr/wdata      load (we=0) or store (we=1) request
//   data_ack/rdata              completion pulse and registered load word
//   mem_en/we/addr/wdata/rdata  memory-side strobe, write enable, address, data
//   busy                        high whenever a transaction is in progress
module lc3_mem_arbiter #(
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [15:0] fetch_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_wdata,
  output logic        data_ack,
  output logic [15:0] data_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(WAIT_STATES);

  state_t      state, next_state;
  logic [15:0] lat_addr, lat_wdata;
  logic        lat_we;
  logic        lat_is_data;
  logic        last_grant_data;
  logic [1:0]  wait_cnt;
  logic        grant_fetch, grant_data;
  logic        last_access;

  // Grants happen only from IDLE. On a conflict, last_grant_data decides the
  // winner: the port that was not served most recently goes first.
  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state == IDLE) begin
      if (fetch_req && data_req) begin
        if (last_grant_data) grant_fetch = 1'b1;
        else                 grant_data  = 1'b1;
      end else begin
        grant_fetch = fetch_req;
        grant_data  = data_req;
      end
    end
  end

  // This is the final cycle with mem_en high. On the edge that ends it, read
  // data is captured and the FSM moves to DONE.
  assign last_access = ((state == ACCESS) && (WAIT_STATES == 0)) ||
                       ((state == WAIT) && (wait_cnt == 2'd1));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // The memory bus is driven only during ACCESS/WAIT, so the async reset of
  // state drops mem_en/mem_we immediately.
  always_comb begin
    next_state = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    fetch_ack  = 1'b0;
    data_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_fetch || grant_data) next_state = ACCESS;
      end
      ACCESS, WAIT: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (last_access)           next_state = DONE;
        else if (state == ACCESS)  next_state = WAIT;
      end
      DONE: begin
        fetch_ack  = ~lat_is_data;
        data_ack   = lat_is_data;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are latched at grant time, so the requester may change them
  // afterwards without disturbing the access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_addr        <= 16'h0000;
      lat_wdata       <= 16'h0000;
      lat_we          <= 1'b0;
      lat_is_data     <= 1'b0;
      last_grant_data <= 1'b1;
      wait_cnt        <= 2'd0;
      fetch_data      <= 16'h0000;
      data_rdata      <= 16'h0000;
    end else begin
      if (grant_fetch || grant_data) begin
        lat_addr        <= grant_data ? data_addr : fetch_addr;
        lat_wdata       <= grant_data ? data_wdata : 16'h0000;
        lat_we          <= grant_data & data_we;
        lat_is_data     <= grant_data;
        last_grant_data <= grant_data;
      end
      if (state == ACCESS)     wait_cnt <= WAIT_LOAD;
      else if (state == WAIT)  wait_cnt <= wait_cnt - 2'd1;
      if (last_access && !lat_we) begin
        if (lat_is_data) data_rdata <= mem_rdata;
        else             fetch_data <= mem_rdata;
      end
    end
  end

endmodule
